// File: rtl/exc_sequencer_if.sv
// WB/CP0/fetch-side signal bundle for the exception sequencer.
// The sequencer takes the slave modport; the WB/CP0/fetch environment takes the master modport.
interface exc_sequencer_if;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic [31:0] wb_br_pc;
  logic        exc_if_adel;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] mem_vaddr;
  logic        wb_eret;
  logic        int_pending;
  logic [31:0] epc_i;
  logic        redirect_ready;
  logic        wb_stall;
  logic        ex_valid_o;
  logic [4:0]  ex_code_o;
  logic        ex_bd_o;
  logic [31:0] ex_pc_o;
  logic        badvaddr_valid_o;
  logic [31:0] badvaddr_o;
  logic        eret_o;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport slave (
    input  wb_valid, wb_pc, wb_bd, wb_br_pc, exc_if_adel, exc_ri, exc_ov, exc_sys,
           exc_bp, exc_adel, exc_ades, mem_vaddr, wb_eret, int_pending, epc_i,
           redirect_ready,
    output wb_stall, ex_valid_o, ex_code_o, ex_bd_o, ex_pc_o, badvaddr_valid_o,
           badvaddr_o, eret_o, flush, redirect_valid, redirect_pc, busy
  );

  modport master (
    output wb_valid, wb_pc, wb_bd, wb_br_pc, exc_if_adel, exc_ri, exc_ov, exc_sys,
           exc_bp, exc_adel, exc_ades, mem_vaddr, wb_eret, int_pending, epc_i,
           redirect_ready,
    input  wb_stall, ex_valid_o, ex_code_o, ex_bd_o, ex_pc_o, badvaddr_valid_o,
           badvaddr_o, eret_o, flush, redirect_valid, redirect_pc, busy
  );
endinterface

// File: rtl/exc_sequencer.sv
// Exception/interrupt/ERET commit sequencer: one CP0 commit cycle, FLUSH_CYCLES of flush,
// then a ready/valid redirect to fetch held until accepted (trigger -> commit is 1 cycle).
module exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             resetn,
  exc_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COMMIT   = 2'd1;
  localparam logic [1:0] S_FLUSH    = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic [31:0] epc_q, epc_d;
  logic        bv_q, bv_d;
  logic [31:0] bad_q, bad_d;
  logic        eret_q, eret_d;
  logic [31:0] tgt_q, tgt_d;

  logic        any_exc;
  logic        trig;
  logic [4:0]  sel_code;
  logic        sel_bv;
  logic [31:0] sel_bad;
  logic        sel_eret;

  assign any_exc = bus.exc_if_adel | bus.exc_ri | bus.exc_ov | bus.exc_sys |
                   bus.exc_bp | bus.exc_adel | bus.exc_ades;
  assign trig    = bus.wb_valid & (bus.int_pending | any_exc | bus.wb_eret);
  assign sel_eret = bus.wb_eret & ~bus.int_pending & ~any_exc;

  // Priority encoder: only the winning event's code and bad address are captured.
  always_comb begin
    sel_code = 5'd0;
    sel_bv   = 1'b0;
    sel_bad  = 32'h0;
    if (bus.int_pending) begin
      sel_code = 5'd0;
    end else if (bus.exc_if_adel) begin
      sel_code = 5'd4;
      sel_bv   = 1'b1;
      sel_bad  = bus.wb_pc;
    end else if (bus.exc_ri) begin
      sel_code = 5'd10;
    end else if (bus.exc_ov) begin
      sel_code = 5'd12;
    end else if (bus.exc_sys) begin
      sel_code = 5'd8;
    end else if (bus.exc_bp) begin
      sel_code = 5'd9;
    end else if (bus.exc_adel) begin
      sel_code = 5'd4;
      sel_bv   = 1'b1;
      sel_bad  = bus.mem_vaddr;
    end else if (bus.exc_ades) begin
      sel_code = 5'd5;
      sel_bv   = 1'b1;
      sel_bad  = bus.mem_vaddr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    bd_d    = bd_q;
    epc_d   = epc_q;
    bv_d    = bv_q;
    bad_d   = bad_q;
    eret_d  = eret_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_COMMIT;
          code_d  = sel_code;
          bd_d    = bus.wb_bd;
          epc_d   = bus.wb_bd ? bus.wb_br_pc : bus.wb_pc;
          bv_d    = sel_bv;
          bad_d   = sel_bad;
          eret_d  = sel_eret;
          tgt_d   = sel_eret ? bus.epc_i : EXC_VECTOR;
        end
      end
      S_COMMIT: begin
        state_d = S_FLUSH;
        cnt_d   = FLUSH_LOAD;
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = S_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (bus.redirect_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      code_q  <= 5'd0;
      bd_q    <= 1'b0;
      epc_q   <= 32'h0;
      bv_q    <= 1'b0;
      bad_q   <= 32'h0;
      eret_q  <= 1'b0;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      epc_q   <= epc_d;
      bv_q    <= bv_d;
      bad_q   <= bad_d;
      eret_q  <= eret_d;
      tgt_q   <= tgt_d;
    end
  end

  // WB must stay valid through COMMIT so CP0 can gate its own writes on it.
  assign bus.wb_stall         = ((state_q == S_IDLE) & trig) | (state_q == S_COMMIT);
  assign bus.ex_valid_o       = (state_q == S_COMMIT) & ~eret_q;
  assign bus.eret_o           = (state_q == S_COMMIT) & eret_q;
  assign bus.ex_code_o        = code_q;
  assign bus.ex_bd_o          = bd_q;
  assign bus.ex_pc_o          = epc_q;
  assign bus.badvaddr_valid_o = (state_q == S_COMMIT) & bv_q;
  assign bus.badvaddr_o       = bad_q;
  assign bus.flush            = (state_q == S_FLUSH) | (state_q == S_REDIRECT);
  assign bus.redirect_valid   = (state_q == S_REDIRECT);
  assign bus.redirect_pc      = (state_q == S_REDIRECT) ? tgt_q : 32'h0;
  assign bus.busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed, table-driven bench for exc_sequencer plus hand sequences for reset-mid-flush,
// redirect backpressure and the wb_valid=0 no-trigger case.
module tb_exc_sequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exc_sequencer_if bus();

  exc_sequencer #(.EXC_VECTOR(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // flags = {int, if_adel, ri, ov, sys, bp, adel, ades, eret, bd}
  typedef struct {
    logic [9:0]  flags;
    logic [31:0] pc;
    logic [31:0] br_pc;
    logic [31:0] vaddr;
    logic [31:0] epc;
    logic        x_ex;
    logic        x_eret;
    logic [4:0]  x_code;
    logic        x_bd;
    logic [31:0] x_epc;
    logic        x_bv;
    logic [31:0] x_bad;
    logic [31:0] x_tgt;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.wb_valid = 1'b0;
    {bus.int_pending, bus.exc_if_adel, bus.exc_ri, bus.exc_ov, bus.exc_sys,
     bus.exc_bp, bus.exc_adel, bus.exc_ades, bus.wb_eret, bus.wb_bd} = 10'b0;
    bus.wb_pc = 32'h0;
    bus.wb_br_pc = 32'h0;
    bus.mem_vaddr = 32'h0;
    bus.epc_i = 32'h0;
  endtask

  task automatic apply(input vec_t v);
    bus.wb_valid = 1'b1;
    {bus.int_pending, bus.exc_if_adel, bus.exc_ri, bus.exc_ov, bus.exc_sys,
     bus.exc_bp, bus.exc_adel, bus.exc_ades, bus.wb_eret, bus.wb_bd} = v.flags;
    bus.wb_pc = v.pc;
    bus.wb_br_pc = v.br_pc;
    bus.mem_vaddr = v.vaddr;
    bus.epc_i = v.epc;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int nflush;
    int n;
    @(negedge clk);
    apply(v);
    #1 chk({nm, ".stall_idle"}, bus.wb_stall, 1);
    @(negedge clk);
    // COMMIT cycle; WB inputs still held valid
    chk({nm, ".ex_valid"}, bus.ex_valid_o, v.x_ex);
    chk({nm, ".eret"}, bus.eret_o, v.x_eret);
    chk({nm, ".stall_commit"}, bus.wb_stall, 1);
    chk({nm, ".flush_commit"}, bus.flush, 0);
    if (v.x_ex) begin
      chk({nm, ".code"}, bus.ex_code_o, v.x_code);
      chk({nm, ".bd"}, bus.ex_bd_o, v.x_bd);
      chk({nm, ".epc"}, bus.ex_pc_o, v.x_epc);
      chk({nm, ".bv"}, bus.badvaddr_valid_o, v.x_bv);
      if (v.x_bv) chk({nm, ".badvaddr"}, bus.badvaddr_o, v.x_bad);
    end
    @(negedge clk);
    // First FLUSH cycle: trigger still presented but must be ignored while busy
    chk({nm, ".commit_1cyc"}, bus.ex_valid_o | bus.eret_o, 0);
    chk({nm, ".stall_busy"}, bus.wb_stall, 0);
    clear_inputs();
    nflush = 0;
    n = 0;
    while (!bus.redirect_valid && n < 20) begin
      if (bus.flush) nflush++;
      @(negedge clk);
      n++;
    end
    if (!bus.redirect_valid) begin
      errors++;
      checks++;
      $display("FAIL %s.redirect_timeout: redirect_valid 0 after 20 cycles, expected 1", nm);
      return;
    end
    chk({nm, ".flush_cycles"}, nflush, 2);
    chk({nm, ".redirect_pc"}, bus.redirect_pc, v.x_tgt);
    chk({nm, ".flush_redir"}, bus.flush, 1);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk({nm, ".hold_valid"}, bus.redirect_valid, 1);
      chk({nm, ".hold_pc"}, bus.redirect_pc, v.x_tgt);
      chk({nm, ".hold_busy"}, bus.busy, 1);
    end
    bus.redirect_ready = 1'b1;
    @(negedge clk);
    bus.redirect_ready = 1'b0;
    chk({nm, ".idle_busy"}, bus.busy, 0);
    chk({nm, ".idle_redir"}, bus.redirect_valid, 0);
    chk({nm, ".idle_flush"}, bus.flush, 0);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".busy"}, bus.busy, 0);
    chk({nm, ".flush"}, bus.flush, 0);
    chk({nm, ".ex_valid"}, bus.ex_valid_o, 0);
    chk({nm, ".eret"}, bus.eret_o, 0);
    chk({nm, ".redir"}, bus.redirect_valid, 0);
    chk({nm, ".redir_pc"}, bus.redirect_pc, 0);
    chk({nm, ".stall"}, bus.wb_stall, 0);
    chk({nm, ".code"}, bus.ex_code_o, 0);
    chk({nm, ".bd"}, bus.ex_bd_o, 0);
    chk({nm, ".epc"}, bus.ex_pc_o, 0);
    chk({nm, ".bv"}, bus.badvaddr_valid_o, 0);
    chk({nm, ".bad"}, bus.badvaddr_o, 0);
  endtask

  initial begin
    //          flags          pc           br_pc        vaddr        epc          ex  er  code bd epc          bv bad          tgt          hold
    vecs[0]  = '{10'b0000100000, 32'h100, 32'h0,   32'h0,    32'h0,    1, 0, 8,  0, 32'h100, 0, 32'h0,    32'h0,    0};
    vecs[1]  = '{10'b0010100001, 32'h200, 32'h1FC, 32'h0,    32'h0,    1, 0, 10, 1, 32'h1FC, 0, 32'h0,    32'h0,    0};
    vecs[2]  = '{10'b0000001000, 32'h300, 32'h0,   32'h1003, 32'h0,    1, 0, 4,  0, 32'h300, 1, 32'h1003, 32'h0,    0};
    vecs[3]  = '{10'b0000000010, 32'h400, 32'h0,   32'h0,    32'h2040, 0, 1, 0,  0, 32'h400, 0, 32'h0,    32'h2040, 0};
    vecs[4]  = '{10'b1001000000, 32'h500, 32'h0,   32'h0,    32'h0,    1, 0, 0,  0, 32'h500, 0, 32'h0,    32'h0,    5};
    vecs[5]  = '{10'b0000010000, 32'h600, 32'h0,   32'h0,    32'h0,    1, 0, 9,  0, 32'h600, 0, 32'h0,    32'h0,    0};
    vecs[6]  = '{10'b0000000100, 32'h700, 32'h0,   32'h2002, 32'h0,    1, 0, 5,  0, 32'h700, 1, 32'h2002, 32'h0,    0};
    vecs[7]  = '{10'b0100001000, 32'h801, 32'h0,   32'h9999, 32'h0,    1, 0, 4,  0, 32'h801, 1, 32'h801,  32'h0,    0};
    vecs[8]  = '{10'b0001110000, 32'h880, 32'h0,   32'h0,    32'h0,    1, 0, 12, 0, 32'h880, 0, 32'h0,    32'h0,    0};
    vecs[9]  = '{10'b1100000000, 32'h903, 32'h0,   32'h0,    32'h0,    1, 0, 0,  0, 32'h903, 0, 32'h0,    32'h0,    0};
    vecs[10] = '{10'b0000100010, 32'h940, 32'h0,   32'h0,    32'h3000, 1, 0, 8,  0, 32'h940, 0, 32'h0,    32'h0,    0};
    vecs[11] = '{10'b1000000001, 32'hA04, 32'hA00, 32'h0,    32'h0,    1, 0, 0,  1, 32'hA00, 0, 32'h0,    32'h0,    0};

    clear_inputs();
    bus.redirect_ready = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;

    // wb_valid low with every flag set must not trigger
    @(negedge clk);
    {bus.int_pending, bus.exc_if_adel, bus.exc_ri, bus.exc_ov, bus.exc_sys,
     bus.exc_bp, bus.exc_adel, bus.exc_ades, bus.wb_eret, bus.wb_bd} = 10'h3FF;
    #1 chk("novalid.stall", bus.wb_stall, 0);
    @(negedge clk);
    chk("novalid.busy", bus.busy, 0);
    chk("novalid.ex_valid", bus.ex_valid_o, 0);
    clear_inputs();

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted in the middle of FLUSH
    @(negedge clk);
    apply(vecs[1]);
    @(negedge clk);
    @(negedge clk);
    clear_inputs();
    chk("midrst.in_flush", bus.flush, 1);
    resetn = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    resetn = 1'b1;
    run_vec(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
